// File: rtl/pc_io_pkg.sv
// Word layout shared by the PC-bound packer and the downstream parser.
// MSB 0 marks BD passthrough and MSB 1 marks an FPGA-originated word.
package pc_io_pkg;

  localparam int unsigned NPCout  = 24;
  localparam int unsigned NBDdata = 21;
  localparam int unsigned Nconf   = 16;

  localparam int unsigned FPGA_OR_BD_BIT  = NPCout - 1;
  localparam int unsigned REG_OR_CHAN_BIT = NPCout - 2;
  localparam int unsigned IdW             = NPCout - 2 - Nconf;

  function automatic logic [NPCout-1:0] pack_bd_word(input logic [NBDdata-1:0] data);
    logic [NPCout-1:0] w;
    w                 = '0;
    w[NBDdata-1:0]    = data;
    w[FPGA_OR_BD_BIT] = 1'b0;
    return w;
  endfunction

  function automatic logic [NPCout-1:0] pack_report_word(input logic [IdW-1:0]   id,
                                                         input logic [Nconf-1:0] data);
    logic [NPCout-1:0] w;
    w                  = '0;
    w[FPGA_OR_BD_BIT]  = 1'b1;
    w[REG_OR_CHAN_BIT] = 1'b1;
    w[Nconf +: IdW]    = id;
    w[Nconf-1:0]       = data;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (cyclically).
// The pointer advances past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    grant_onehot = '0;
    grant_valid  = 1'b0;
    ptr_d        = ptr_q;
    idx          = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid       = 1'b1;
        grant_onehot[idx] = 1'b1;
        ptr_d             = (idx + 1 == N) ? '0 : PtrW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pc_packer.sv
// Merges BD words and FPGA report channels into one registered PC-bound stream
// through a round-robin arbiter and a 2-entry output buffer.
module pc_packer
  import pc_io_pkg::*;
#(
  parameter int unsigned Nchan = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   BD_data_in_v,
  output logic                   BD_data_in_a,
  input  logic [NBDdata-1:0]     BD_data_in_d,
  input  logic [Nchan-1:0]       report_channel_in_v,
  output logic [Nchan-1:0]       report_channel_in_a,
  input  logic [Nchan*Nconf-1:0] report_channel_in_d,
  output logic                   PC_out_v,
  input  logic                   PC_out_a,
  output logic [NPCout-1:0]      PC_out_d
);

  localparam int unsigned NReq = Nchan + 1;

  logic [NReq-1:0]   req, grant_onehot;
  logic              grant_valid, accept, pop;
  logic [NPCout-1:0] in_word;
  logic [NPCout-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  assign req = {BD_data_in_v, report_channel_in_v};

  // Gated by reset so no source is acked while held in reset; PC_out_a is deliberately
  // not used here, so a freed slot is only reused on the following cycle.
  assign accept              = reset && grant_valid && (count_q != 2'd2);
  assign report_channel_in_a = grant_onehot[Nchan-1:0] & {Nchan{accept}};
  assign BD_data_in_a        = grant_onehot[Nchan] & accept;

  assign PC_out_v = (count_q != 2'd0);
  assign PC_out_d = head_q;
  assign pop      = PC_out_v && PC_out_a;

  rr_arbiter #(
    .N(NReq)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .accept       (accept),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid)
  );

  always_comb begin
    in_word = pack_bd_word(BD_data_in_d);
    for (int unsigned i = 0; i < Nchan; i++) begin
      if (grant_onehot[i]) begin
        in_word = pack_report_word(IdW'(i), report_channel_in_d[i*Nconf +: Nconf]);
      end
    end
  end

  // head_q is the output register; it keeps its value when the buffer drains.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (accept) begin
          head_d  = in_word;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (accept && pop) begin
          head_d = in_word;
        end else if (accept) begin
          tail_d  = in_word;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pc_packer.sv
// Randomized bench for pc_packer against a queue-based scoreboard and a cyclic-search
// arbitration model, plus directed reset, latency, round-robin and backpressure cases.
module tb_pc_packer;
  import pc_io_pkg::*;

  localparam int unsigned Nchan = 4;
  localparam int unsigned NSrc  = Nchan + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   bd_v, bd_a;
  logic [NBDdata-1:0]     bd_d;
  logic [Nchan-1:0]       rc_v, rc_a;
  logic [Nchan*Nconf-1:0] rc_d;
  logic                   pc_v, pc_a;
  logic [NPCout-1:0]      pc_d;

  pc_packer #(
    .Nchan(Nchan)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .BD_data_in_v        (bd_v),
    .BD_data_in_a        (bd_a),
    .BD_data_in_d        (bd_d),
    .report_channel_in_v (rc_v),
    .report_channel_in_a (rc_a),
    .report_channel_in_d (rc_d),
    .PC_out_v            (pc_v),
    .PC_out_a            (pc_a),
    .PC_out_d            (pc_d)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        src_v [NSrc];
  logic [20:0] src_d [NSrc];
  logic [23:0] sb[$];
  int          ptr_m      = 0;
  int          last_ack   = -1;
  int          n_dut_acc  = 0;
  bit          keep_valid = 1'b1;
  bit          rand_pc_a  = 1'b0;
  int          p_new      = 0;
  logic        pc_v_seen;
  logic [23:0] pc_d_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_word(input int src, input logic [20:0] d);
    int w;
    if (src == Nchan) w = int'(d);
    else w = 'hC00000 + src * 65536 + int'(d[15:0]);
    return w[23:0];
  endfunction

  task automatic drive();
    for (int i = 0; i < Nchan; i++) begin
      rc_v[i]                = src_v[i];
      rc_d[i*Nconf +: Nconf] = src_d[i][15:0];
    end
    bd_v = src_v[Nchan];
    bd_d = src_d[Nchan];
  endtask

  // Called at negedge: compare DUT against the model, then apply this cycle's edge to it.
  task automatic eval();
    int               g;
    bit               exp_acc;
    logic [NSrc-1:0]  exp_a;
    g = -1;
    for (int k = 0; k < NSrc; k++) begin
      int idx;
      idx = (ptr_m + k) % NSrc;
      if (g < 0 && src_v[idx]) g = idx;
    end
    exp_acc = reset && (g >= 0) && (sb.size() < 2);
    exp_a   = '0;
    if (exp_acc) exp_a[g] = 1'b1;
    check_eq("acks", {bd_a, rc_a}, exp_a);
    check_eq("pc_v", pc_v, sb.size() != 0);
    if (sb.size() != 0) check_eq("pc_d", pc_d, sb[0]);
    pc_v_seen = pc_v;
    pc_d_seen = pc_d;
    if (|{bd_a, rc_a}) n_dut_acc++;
    last_ack = exp_acc ? g : -1;
    if (pc_a && sb.size() != 0) void'(sb.pop_front());
    if (exp_acc) begin
      sb.push_back(ref_word(g, src_d[g]));
      ptr_m = (g + 1) % NSrc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    for (int i = 0; i < NSrc; i++) begin
      if (i == last_ack) begin
        src_v[i] = keep_valid ? 1'b1 : ($urandom_range(99) < p_new);
        src_d[i] = 21'($urandom());
      end else if (!src_v[i] && $urandom_range(99) < p_new) begin
        src_v[i] = 1'b1;
        src_d[i] = 21'($urandom());
      end
    end
    if (rand_pc_a) pc_a = 1'($urandom_range(1));
    drive();
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and releases it after the next edge.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_pc_v", pc_v, 1'b0);
    check_eq("rst_pc_d", pc_d, 24'h0);
    check_eq("rst_acks", {bd_a, rc_a}, '0);
    sb.delete();
    ptr_m = 0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < NSrc; i++) begin
      src_v[i] = v;
      src_d[i] = 21'($urandom());
    end
    drive();
  endtask

  initial begin
    reset = 1'b0;
    pc_a  = 1'b1;
    set_all(1'b1);
    repeat (2) begin
      @(negedge clk);
      check_eq("hold_acks", {bd_a, rc_a}, '0);
      check_eq("hold_pc_v", pc_v, 1'b0);
      check_eq("hold_pc_d", pc_d, 24'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    check_eq("first_grant", last_ack, 0);
    check_eq("first_latency_v", pc_v_seen, 1'b0);
    step();
    check_eq("first_out_v", pc_v_seen, 1'b1);

    // BD only
    keep_valid = 1'b0;
    set_all(1'b0);
    reset_pulse();
    src_v[Nchan] = 1'b1;
    src_d[Nchan] = 21'h1ABCDE;
    drive();
    step();
    check_eq("bd_grant", last_ack, Nchan);
    step();
    check_eq("bd_word", pc_d_seen, 24'h1ABCDE);

    // Report channel 2 only
    reset_pulse();
    src_v[2] = 1'b1;
    src_d[2] = 21'h00BEEF;
    drive();
    step();
    check_eq("rpt_grant", last_ack, 2);
    step();
    check_eq("rpt_word", pc_d_seen, 24'hC2BEEF);
    step();

    // Round robin with every source valid
    keep_valid = 1'b1;
    set_all(1'b1);
    reset_pulse();
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq("rr_order", last_ack, k % NSrc);
    end

    // Backpressure from an empty buffer
    reset_pulse();
    pc_a      = 1'b0;
    n_dut_acc = 0;
    repeat (6) step();
    check_eq("bp_accepts", n_dut_acc, 2);
    pc_a = 1'b1;
    repeat (6) step();

    // Fill to two entries, then reset mid-stream
    pc_a = 1'b0;
    repeat (3) step();
    check_eq("bp_full_v", pc_v_seen, 1'b1);
    reset_pulse();
    pc_a = 1'b1;
    step();
    check_eq("rst_first_grant", last_ack, 0);

    // Random traffic with random backpressure
    keep_valid = 1'b0;
    p_new      = 40;
    rand_pc_a  = 1'b1;
    repeat (400) step();

    p_new     = 0;
    rand_pc_a = 1'b0;
    pc_a      = 1'b1;
    set_all(1'b0);
    repeat (4) step();
    check_eq("drained", pc_v_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_packer.md
# pc_packer

Assembles the PC-bound word stream from the FPGA side: merges BD output words and FPGA report channels into one 24-bit upstream channel. It uses the same word layout the downstream parser decodes: MSB 0 for BD passthrough, MSB 1 for FPGA words. A round-robin arbiter picks one source per cycle into a 2-entry output buffer, so the PC-facing channel is registered and fairly shared.

## Interface
- NPCout, 24, PC-bound word width
- NBDdata, 21, BD data width
- Nconf, 16, report channel data width
- Nchan, 8, number of FPGA report channels; must be ≤ 2**(NPCout-2-Nconf)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- BD_data_in  Channel  NBDdata  words from BD, to be passed upstream
- report_channel_in  ChannelArray  Nchan × Nconf  FPGA report words, channel i has id i
- PC_out  Channel  NPCout  packed words to PC

## Operation
- Channel handshake: a transfer happens in a cycle with v=1 and a=1. A source holds d stable while v=1 until acked. a never asserts without v.
- Word formats: bit positions are fixed.
  - BD word: {1'b0, 2'b00, BD_data}.
  - Report word: {1'b1, 1'b1, id[NPCout-2-Nconf-1:0], data}. id is zero-extended i.
- Arbitration: there are Nchan+1 requesters. Index i<Nchan is report_channel_in[i]; index Nchan is BD_data_in.
  - Pointer ptr ∈ [0, Nchan], reset 0.
  - The grant goes to the first requester with v=1, searching cyclically from ptr.
  - On an accepted grant g: ptr ← (g+1) mod (Nchan+1). ptr does not change without an accept.
- Accept condition: grant exists and buffer count < 2. The granted source's a=1 combinationally in that cycle; all other a=0.
  - There is no combinational path from PC_out.a to any input a.
- Output buffer: 2-entry FIFO.
  - PC_out.v = (count ≠ 0); PC_out.d = head entry.
  - Pop when PC_out.v && PC_out.a.
- Push and pop in the same cycle: both occur, count is unchanged, and order is preserved.
- Full (count=2): no input acked. Only a pop frees space, and the next accept occurs in the following cycle.
- Empty: PC_out.v=0 and PC_out.d holds its last value (0 after reset).
- Asserting reset mid-operation immediately clears the buffer, ptr, and PC_out.v. Buffered words are lost; sources keep their v and retry after release.

## Timing
- Reset values: PC_out.v=0, PC_out.d=0, count=0, ptr=0. All input a are 0 while reset is asserted.
- Latency: a word accepted at edge t appears on PC_out from cycle t+1 (1 cycle).
- Throughput: 1 word/cycle while PC_out.a is held 1.
- With count=1 and a pop each cycle, every cycle also accepts, so the buffer never stalls the inputs.
- Fairness: with all Nchan+1 sources continuously valid and no backpressure, each source is served exactly once per Nchan+1 accepted words.
- The PC_out.d ordering of words always equals the input accept order.

## Structure
- Shared package pc_io_pkg holds:
  - NPCout, NBDdata, Nconf.
  - Header bit positions: FPGA_OR_BD_BIT = NPCout-1, REG_OR_CHAN_BIT = NPCout-2.
  - Id field width NPCout-2-Nconf.
  - Packing functions pack_bd_word and pack_report_word.
- The downstream parser uses the same package constants.
- Sub-module rr_arbiter #(N) holds the round-robin pointer and grant logic.
  - Ports: clk, reset, req[N], accept, grant_onehot[N], grant_valid.
- FIFO, packing and ack generation live in pc_packer.

## Test plan
Bench uses Nchan=4 and a 6-bit id field.
- Reset hold: reset=0 with all sources valid → all a=0, PC_out.v=0, PC_out.d=0; release → first PC_out word appears one cycle after the first accept.
- BD only: BD_data_in.d=21'h1ABCDE, PC_out.a=1 → PC_out.d=24'h1ABCDE one cycle after accept.
- Report only: report_channel_in[2].d=16'hBEEF → PC_out.d=24'hC2BEEF.
- Round robin: all 5 sources constantly valid, PC_out.a=1 → ids in order ch0, ch1, ch2, ch3, BD, ch0, …; each source acked once per 5 words.
- Backpressure: PC_out.a=0 for 6 cycles with sources valid → exactly 2 accepts, then all a=0; PC_out.a=1 → buffered words emerge in accept order with no loss or duplication.
- Mid-stream reset: reset asserted with count=2 → PC_out.v=0 immediately; after release ptr=0 and ch0 is granted first.
